// File: rtl/ttl_counter_pkg.sv
// Shared encodings and helpers for the cascaded TTL-style counter.
package ttl_counter_pkg;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_RELOAD  = 2'd2
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } os_state_e;

  // Saturate a load value into the legal per-stage range 0..modulus-1.
  function automatic int unsigned clamp_to_modulus(input int unsigned value,
                                                   input int unsigned modulus);
    return (value >= modulus) ? modulus - 1 : value;
  endfunction

endpackage

// File: rtl/ttl_counter_stage.sv
// One modulo-MODULUS digit: up/down step, parallel load with clamping, and
// a reload select that swaps the natural wrap for the (clamped) load value.
module ttl_counter_stage
  import ttl_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             en,
  input  logic             load,
  input  logic             reload,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] d_clamped;

  assign d_clamped = WIDTH'(clamp_to_modulus(32'(d), MODULUS));

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load || (en && reload)) begin
      q <= d_clamped;
    end else if (en) begin
      if (up) q <= (q == TOP) ? '0 : q + WIDTH'(1);
      else    q <= (q == '0) ? TOP : q - WIDTH'(1);
    end
  end

  assign tc = up ? (q == TOP) : (q == '0);

endmodule

// File: rtl/ttl_cascade_counter.sv
// Cascaded synchronous counter: STAGES digits of WIDTH bits modulo MODULUS,
// with FREE / ONESHOT / RELOAD run modes. TTL_CASCADE_CAPTURE_EN adds Capture/Q_cap.
module ttl_cascade_counter
  import ttl_counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned MODULUS    = 16,
  parameter int          DELAY_RISE = 0,
  parameter int          DELAY_FALL = 0
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Load_bar,
  input  logic                      ENT,
  input  logic                      ENP,
  input  logic                      Up,
  input  logic [1:0]                Mode,
  input  logic [WIDTH*STAGES-1:0]   D,
`ifdef TTL_CASCADE_CAPTURE_EN
  input  logic                      Capture,
  output logic [WIDTH*STAGES-1:0]   Q_cap,
`endif
  output logic [WIDTH*STAGES-1:0]   Q,
  output logic [STAGES-1:0]         Stage_RCO,
  output logic                      RCO,
  output logic                      Done
);

  // Delay parameters exist for drop-in compatibility with the discrete models;
  // they carry no timing in this implementation.
  if (STAGES < 1 || STAGES > 8 || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
      DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_param_check
    $error("ttl_cascade_counter: illegal parameter set");
  end

  logic [STAGES-1:0] tc;
  logic [STAGES-1:0] chain;
  logic [STAGES-1:0] step;
  os_state_e         state_q, state_d;
  logic              done_q, done_d;
  logic              is_oneshot, is_reload;
  logic              cnt, chain_event, reload_sel;

  assign is_oneshot  = (Mode == MODE_ONESHOT);
  assign is_reload   = (Mode == MODE_RELOAD);
  assign cnt         = ENT & ENP & Load_bar & ~(is_oneshot & (state_q == ST_DONE));
  assign chain_event = cnt & RCO;
  assign reload_sel  = chain_event & is_reload;

  // Running AND of terminal flags from stage 0 upward.
  always_comb begin
    logic acc;
    acc   = 1'b1;
    chain = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      acc      = acc & tc[k];
      chain[k] = acc;
    end
  end

  // A stage steps when all lower stages are terminal; ONESHOT freezes at terminal.
  always_comb begin
    step = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      step[k] = cnt & ((k == 0) ? 1'b1 : chain[k-1]) & ~(chain_event & is_oneshot);
    end
  end

  assign Stage_RCO = {STAGES{ENT}} & chain;
  assign RCO       = Stage_RCO[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ttl_counter_stage #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
    ) u_stage (
      .clk    (Clk),
      .reset  (Reset),
      .up     (Up),
      .en     (step[k]),
      .load   (~Load_bar),
      .reload (reload_sel),
      .d      (D[k*WIDTH +: WIDTH]),
      .q      (Q[k*WIDTH +: WIDTH]),
      .tc     (tc[k])
    );
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Done pulses after a chain event; in ONESHOT it latches until load or mode change.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (!Load_bar) begin
      state_d = ST_RUN;
    end else if (chain_event) begin
      done_d  = 1'b1;
      state_d = is_oneshot ? ST_DONE : ST_RUN;
    end else if (state_q == ST_DONE) begin
      if (is_oneshot) done_d = 1'b1;
      else            state_d = ST_RUN;
    end
  end

  assign Done = done_q;

`ifdef TTL_CASCADE_CAPTURE_EN
  always_ff @(posedge Clk) begin
    if (Reset)        Q_cap <= '0;
    else if (Capture) Q_cap <= Q;
  end
`endif

endmodule

// File: tb/tb_ttl_cascade_counter.sv
// Directed bench for ttl_cascade_counter in the BCD configuration (4x2, modulo 10).
module tb_ttl_cascade_counter;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned STAGES  = 2;
  localparam int unsigned MODULUS = 10;
  localparam int unsigned QW      = WIDTH * STAGES;

  logic              Clk = 1'b0;
  logic              Reset, Load_bar, ENT, ENP, Up;
  logic [1:0]        Mode;
  logic [QW-1:0]     D, Q;
  logic [STAGES-1:0] Stage_RCO;
  logic              RCO, Done;
`ifdef TTL_CASCADE_CAPTURE_EN
  logic              Capture;
  logic [QW-1:0]     Q_cap;
`endif

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  ttl_cascade_counter #(
    .WIDTH   (WIDTH),
    .STAGES  (STAGES),
    .MODULUS (MODULUS)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load_bar  (Load_bar),
    .ENT       (ENT),
    .ENP       (ENP),
    .Up        (Up),
    .Mode      (Mode),
    .D         (D),
`ifdef TTL_CASCADE_CAPTURE_EN
    .Capture   (Capture),
    .Q_cap     (Q_cap),
`endif
    .Q         (Q),
    .Stage_RCO (Stage_RCO),
    .RCO       (RCO),
    .Done      (Done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [QW-1:0] v);
    Load_bar = 1'b0;
    D        = v;
    tick();
    Load_bar = 1'b1;
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  initial begin
    Reset = 1'b1; Load_bar = 1'b1; ENT = 1'b0; ENP = 1'b0;
    Up = 1'b1; Mode = 2'd0; D = '0;
`ifdef TTL_CASCADE_CAPTURE_EN
    Capture = 1'b0;
`endif
    tick();
    tick();
    check("rst_q", 32'(Q), 32'h00);
    check("rst_done", 32'(Done), 32'h0);
    check("rst_rco", 32'(RCO), 32'h0);

    // Free-run up through all 100 BCD values and wrap
    Reset = 1'b0; ENT = 1'b1; ENP = 1'b1;
    for (int i = 0; i < 100; i++) begin
      check("up_q", 32'(Q), 32'(bcd(i)));
      check("up_rco", 32'(RCO), 32'(i == 99));
      check("up_done", 32'(Done), 32'h0);
      tick();
    end
    check("up_wrap_q", 32'(Q), 32'h00);
    check("up_wrap_done", 32'(Done), 32'h1);
    tick();
    check("up_done_end", 32'(Done), 32'h0);
    check("up_after_wrap", 32'(Q), 32'h01);

    // Down count from 00: 99, 98 ... 00
    load(8'h00);
    Up = 1'b0;
    #1;
    for (int i = 0; i <= 100; i++) begin
      int v;
      v = (100 - i) % 100;
      check("dn_q", 32'(Q), 32'(bcd(v)));
      check("dn_srco0", 32'(Stage_RCO[0]), 32'((v % 10) == 0));
      check("dn_rco", 32'(RCO), 32'(v == 0));
      if (i == 1) check("dn_done", 32'(Done), 32'h1);
      if (i < 100) tick();
    end

    // One-shot from 05: 94 counts to 99, then freeze with Done latched
    Mode = 2'd1; Up = 1'b1;
    load(8'h05);
    check("os_start", 32'(Q), 32'h05);
    repeat (94) tick();
    check("os_q99", 32'(Q), 32'h99);
    check("os_done0", 32'(Done), 32'h0);
    check("os_rco", 32'(RCO), 32'h1);
    tick();
    check("os_hold_q", 32'(Q), 32'h99);
    check("os_done", 32'(Done), 32'h1);
    for (int i = 0; i < 4; i++) begin
      ENP = i[0];
      tick();
      check("os_hold_q2", 32'(Q), 32'h99);
      check("os_done_stay", 32'(Done), 32'h1);
      check("os_rco_hold", 32'(RCO), 32'h1);
    end
    ENP = 1'b1;
    load(8'h10);
    check("os_load_q", 32'(Q), 32'h10);
    check("os_clear_done", 32'(Done), 32'h0);
    tick();
    check("os_resume", 32'(Q), 32'h11);

    // Auto-reload from 95: 95..99 then back to 95, Done every 5 counts
    Mode = 2'd2;
    load(8'h95);
    for (int i = 0; i < 12; i++) begin
      check("rl_q", 32'(Q), 32'(8'h95 + 8'(i % 5)));
      check("rl_done", 32'(Done), 32'(i > 0 && (i % 5) == 0));
      tick();
    end

    // Boundary cases
    Mode = 2'd0;
    Reset = 1'b1; Load_bar = 1'b0; D = 8'h55;
    tick();
    Reset = 1'b0; Load_bar = 1'b1;
    check("rst_over_load", 32'(Q), 32'h00);
    check("rst_over_load_done", 32'(Done), 32'h0);
    load(8'h37);
    check("load_over_count", 32'(Q), 32'h37);
    load(8'h0F);
    check("clamp_lo", 32'(Q), 32'h09);
    load(8'hF3);
    check("clamp_hi", 32'(Q), 32'h93);
    load(8'h99);
    ENT = 1'b0;
    #1;
    check("ent0_rco", 32'(RCO), 32'h0);
    check("ent0_srco", 32'(Stage_RCO), 32'h0);
    tick();
    check("ent0_hold", 32'(Q), 32'h99);
    ENT = 1'b1;
    #1;
    check("ent1_rco", 32'(RCO), 32'h1);
    check("ent1_srco", 32'(Stage_RCO), 32'h3);
    Mode = 2'd3;
    tick();
    check("mode3_wrap_q", 32'(Q), 32'h00);
    check("mode3_wrap_done", 32'(Done), 32'h1);

`ifdef TTL_CASCADE_CAPTURE_EN
    Mode = 2'd0;
    load(8'h40);
    tick();
    tick();
    check("cap_pre_q", 32'(Q), 32'h42);
    Capture = 1'b1;
    tick();
    Capture = 1'b0;
    check("cap_q", 32'(Q), 32'h43);
    check("cap_val", 32'(Q_cap), 32'h42);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("cap_rst", 32'(Q_cap), 32'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
